// File: rtl/reservation_station_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reservation_station_pkg
//  Description : Shared widths, FU class encoding, entry record and wakeup
//                helper used by the reservation station and its picker.
//  Revision    : 1.0 - initial release
// ============================================================================
package reservation_station_pkg;

  localparam int PREG_W = 7;
  localparam int ROB_W  = 4;

  typedef enum logic [1:0] {
    FU_ALU    = 2'b00,
    FU_BRANCH = 2'b01,
    FU_LSU    = 2'b10
  } fu_type_t;

  // Payload width is a per-instance parameter, so the payload is held in a
  // parallel array beside these records rather than inside them.
  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] prs1;
    logic              rdy1;
    logic [PREG_W-1:0] prs2;
    logic              rdy2;
    logic [PREG_W-1:0] prd;
    logic [ROB_W-1:0]  rob_tag;
  } rs_entry_t;

  // True when the broadcast result produces the given source register.
  function automatic logic cdb_hit(input logic              cdb_valid,
                                   input logic [PREG_W-1:0] cdb_preg,
                                   input logic [PREG_W-1:0] prs);
    return cdb_valid && (cdb_preg == prs);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reservation_station_rs_select.sv
`default_nettype none
// ============================================================================
//  Module      : rs_select
//  Description : Lowest-index-first priority picker. Produces a one-hot grant
//                for the oldest ready entry and a flag when any is ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_select #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0] ready,
  output logic [DEPTH-1:0] grant,
  output logic             valid
);

  // Walk from index 0 upward and grant the first ready entry.
  always_comb begin
    logic w_found;
    w_found = 1'b0;
    grant   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && !w_found) begin
        grant[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end

  assign valid = |ready;

endmodule
`default_nettype wire

// File: rtl/reservation_station.sv
`default_nettype none
// ============================================================================
//  Module      : reservation_station
//  Description : Collapsing-queue reservation station. Holds dispatched ops
//                until both operands are ready, offers the oldest ready op to
//                the FU, compacts on issue and wakes sources from the CDB.
//  Revision    : 1.0 - initial release
// ============================================================================
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int PAYLOAD_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc,
  input  logic [PREG_W-1:0]    alloc_prs1,
  input  logic                 alloc_rs1_ready,
  input  logic [PREG_W-1:0]    alloc_prs2,
  input  logic                 alloc_rs2_ready,
  input  logic [PREG_W-1:0]    alloc_prd,
  input  logic [ROB_W-1:0]     alloc_rob_tag,
  input  logic [PAYLOAD_W-1:0] alloc_payload,
  output logic                 full,
  input  logic                 cdb_valid,
  input  logic [PREG_W-1:0]    cdb_preg,
  input  logic                 flush,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  output logic [PREG_W-1:0]    issue_prs1,
  output logic [PREG_W-1:0]    issue_prs2,
  output logic [PREG_W-1:0]    issue_prd,
  output logic [ROB_W-1:0]     issue_rob_tag,
  output logic [PAYLOAD_W-1:0] issue_payload
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  rs_entry_t            r_ent   [DEPTH];
  logic [PAYLOAD_W-1:0] r_pay   [DEPTH];
  logic [CNT_W-1:0]     r_count;
  logic                 r_full;

  rs_entry_t            w_ent_n [DEPTH];
  logic [PAYLOAD_W-1:0] w_pay_n [DEPTH];
  logic [DEPTH-1:0]     w_ready;
  logic [DEPTH-1:0]     w_grant;
  logic [DEPTH-1:0]     w_shift;
  logic                 w_any;
  logic                 w_issue;
  logic                 w_alloc;
  logic [CNT_W-1:0]     w_count_c;
  logic [CNT_W-1:0]     w_count_n;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ready
    assign w_ready[i] = r_ent[i].valid & r_ent[i].rdy1 & r_ent[i].rdy2;
  end

  rs_select #(
    .DEPTH (DEPTH)
  ) u_select (
    .ready (w_ready),
    .grant (w_grant),
    .valid (w_any)
  );

  // Nothing is offered while the queue is being discarded.
  assign issue_valid = w_any & ~flush & ~reset;
  assign w_issue     = issue_valid & issue_ready;
  assign full        = r_full;

  // A full queue that issues in the same cycle frees a slot for the new op.
  assign w_alloc   = alloc & ~flush & (~r_full | w_issue);
  assign w_count_c = r_count - CNT_W'(w_issue);
  assign w_count_n = w_count_c + CNT_W'(w_alloc);

  // Drive the FU-facing fields from the granted (oldest ready) entry.
  always_comb begin
    issue_prs1    = '0;
    issue_prs2    = '0;
    issue_prd     = '0;
    issue_rob_tag = '0;
    issue_payload = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_grant[i]) begin
        issue_prs1    = r_ent[i].prs1;
        issue_prs2    = r_ent[i].prs2;
        issue_prd     = r_ent[i].prd;
        issue_rob_tag = r_ent[i].rob_tag;
        issue_payload = r_pay[i];
      end
    end
  end

  // Entries at or above the issued slot move down by one.
  always_comb begin
    logic w_acc;
    w_acc   = 1'b0;
    w_shift = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_acc      = w_acc | w_grant[i];
      w_shift[i] = w_issue & w_acc;
    end
  end

  // Next entry image: collapse first, then wake shifted entries, then place
  // the new op at the post-collapse tail with same-cycle CDB capture.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_ent_n[i] = r_ent[i];
      w_pay_n[i] = r_pay[i];
      if (w_shift[i]) begin
        w_ent_n[i] = r_ent[(i < DEPTH - 1) ? i + 1 : i];
        w_pay_n[i] = r_pay[(i < DEPTH - 1) ? i + 1 : i];
        if (i == DEPTH - 1) begin
          w_ent_n[i].valid = 1'b0;
        end
      end
      if (w_ent_n[i].valid) begin
        if (cdb_hit(cdb_valid, cdb_preg, w_ent_n[i].prs1)) w_ent_n[i].rdy1 = 1'b1;
        if (cdb_hit(cdb_valid, cdb_preg, w_ent_n[i].prs2)) w_ent_n[i].rdy2 = 1'b1;
      end
      if (w_alloc && (w_count_c == CNT_W'(i))) begin
        w_ent_n[i].valid   = 1'b1;
        w_ent_n[i].prs1    = alloc_prs1;
        w_ent_n[i].rdy1    = alloc_rs1_ready | cdb_hit(cdb_valid, cdb_preg, alloc_prs1);
        w_ent_n[i].prs2    = alloc_prs2;
        w_ent_n[i].rdy2    = alloc_rs2_ready | cdb_hit(cdb_valid, cdb_preg, alloc_prs2);
        w_ent_n[i].prd     = alloc_prd;
        w_ent_n[i].rob_tag = alloc_rob_tag;
        w_pay_n[i]         = alloc_payload;
      end
    end
  end

  // Entry state, occupancy and full flag; reset outranks flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i].valid <= 1'b0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      r_ent   <= w_ent_n;
      r_count <= w_count_n;
      r_full  <= (w_count_n == CNT_W'(DEPTH));
    end
  end

  // Payloads are qualified by the valid bits, so they need no reset.
  always_ff @(posedge clk) begin
    r_pay <= w_pay_n;
  end

endmodule
`default_nettype wire

// File: tb/tb_reservation_station.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reservation_station
//  Description : Directed scoreboard bench for reservation_station.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reservation_station;
  import reservation_station_pkg::*;

  typedef struct packed {
    logic [PREG_W-1:0] prs1;
    logic [PREG_W-1:0] prs2;
    logic [PREG_W-1:0] prd;
    logic [ROB_W-1:0]  rob;
    logic [31:0]       pay;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              alloc = 1'b0;
  logic [PREG_W-1:0] alloc_prs1 = '0;
  logic              alloc_rs1_ready = 1'b0;
  logic [PREG_W-1:0] alloc_prs2 = '0;
  logic              alloc_rs2_ready = 1'b0;
  logic [PREG_W-1:0] alloc_prd = '0;
  logic [ROB_W-1:0]  alloc_rob_tag = '0;
  logic [31:0]       alloc_payload = '0;
  logic              full;
  logic              cdb_valid = 1'b0;
  logic [PREG_W-1:0] cdb_preg = '0;
  logic              flush = 1'b0;
  logic              issue_valid;
  logic              issue_ready = 1'b0;
  logic [PREG_W-1:0] issue_prs1, issue_prs2, issue_prd;
  logic [ROB_W-1:0]  issue_rob_tag;
  logic [31:0]       issue_payload;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  reservation_station #(.DEPTH(8), .PAYLOAD_W(32)) dut (
    .clk(clk), .reset(reset), .alloc(alloc),
    .alloc_prs1(alloc_prs1), .alloc_rs1_ready(alloc_rs1_ready),
    .alloc_prs2(alloc_prs2), .alloc_rs2_ready(alloc_rs2_ready),
    .alloc_prd(alloc_prd), .alloc_rob_tag(alloc_rob_tag),
    .alloc_payload(alloc_payload), .full(full),
    .cdb_valid(cdb_valid), .cdb_preg(cdb_preg), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_prs1(issue_prs1), .issue_prs2(issue_prs2), .issue_prd(issue_prd),
    .issue_rob_tag(issue_rob_tag), .issue_payload(issue_payload)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_alloc(input logic [PREG_W-1:0] p1, input logic r1,
                           input logic [PREG_W-1:0] p2, input logic r2,
                           input logic [PREG_W-1:0] pd, input logic [ROB_W-1:0] rob,
                           input logic [31:0] pay);
    alloc = 1'b1; alloc_prs1 = p1; alloc_rs1_ready = r1;
    alloc_prs2 = p2; alloc_rs2_ready = r2; alloc_prd = pd;
    alloc_rob_tag = rob; alloc_payload = pay;
  endtask

  task automatic push(input logic [PREG_W-1:0] p1, input logic [PREG_W-1:0] p2,
                      input logic [PREG_W-1:0] pd, input logic [ROB_W-1:0] rob,
                      input logic [31:0] pay);
    exp_t e;
    e.prs1 = p1; e.prs2 = p2; e.prd = pd; e.rob = rob; e.pay = pay;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted issue is checked against the next expected op.
  always @(negedge clk) begin
    if (issue_valid === 1'b1 && issue_ready === 1'b1) begin
      exp_t act;
      exp_t exp;
      act = {issue_prs1, issue_prs2, issue_prd, issue_rob_tag, issue_payload};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL issue_unexpected: got payload %0h expected no issue", issue_payload);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          n_bad++;
          $display("FAIL issue_fields: got %0h expected %0h", act, exp);
        end
      end
    end
  end

  initial begin
    // Reset state
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("reset_full", {31'd0, full}, 32'd0);
    chk("reset_issue_valid", {31'd0, issue_valid}, 32'd0);

    // Fill to full with ready ops, nothing accepted by the FU
    for (int i = 0; i < 8; i++) begin
      set_alloc(7'(10 + i), 1'b1, 7'(20 + i), 1'b1, 7'(30 + i), 4'(i), 32'hA000 + 32'(i));
      tick();
      if (i == 6) chk("full_at_7", {31'd0, full}, 32'd0);
    end
    chk("full_at_8", {31'd0, full}, 32'd1);
    set_alloc(7'd99, 1'b1, 7'd98, 1'b1, 7'd97, 4'd15, 32'hDEAD);
    tick();
    alloc = 1'b0;
    #1;
    chk("full_after_9th", {31'd0, full}, 32'd1);
    chk("oldest_offered", issue_payload, 32'hA000);

    // Issue and alloc together on a full queue; new op lands last
    for (int i = 0; i < 8; i++)
      push(7'(10 + i), 7'(20 + i), 7'(30 + i), 4'(i), 32'hA000 + 32'(i));
    push(7'd60, 7'd61, 7'd62, 4'd8, 32'hB000);
    set_alloc(7'd60, 1'b1, 7'd61, 1'b1, 7'd62, 4'd8, 32'hB000);
    issue_ready = 1'b1;
    tick();
    alloc = 1'b0;
    #1;
    chk("full_after_swap", {31'd0, full}, 32'd1);
    tick();
    chk("full_after_drain1", {31'd0, full}, 32'd0);
    for (int i = 0; i < 7; i++) tick();
    issue_ready = 1'b0;
    #1;
    chk("drained_issue_valid", {31'd0, issue_valid}, 32'd0);

    // Wakeup of source 1 via CDB, no same-cycle bypass
    set_alloc(7'd5, 1'b0, 7'd6, 1'b1, 7'd7, 4'd1, 32'hC001);
    tick();
    alloc = 1'b0;
    #1;
    chk("wait_not_ready", {31'd0, issue_valid}, 32'd0);
    cdb_valid = 1'b1; cdb_preg = 7'd5;
    #1;
    chk("wake_no_bypass", {31'd0, issue_valid}, 32'd0);
    tick();
    cdb_valid = 1'b0;
    #1;
    chk("wake_issue_valid", {31'd0, issue_valid}, 32'd1);
    chk("wake_prs1", {25'd0, issue_prs1}, 32'd5);
    push(7'd5, 7'd6, 7'd7, 4'd1, 32'hC001);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;

    // Out-of-order: A waits, B and C go first, A issues after wakeup
    set_alloc(7'd40, 1'b0, 7'd41, 1'b1, 7'd42, 4'd2, 32'hD00A); tick();
    set_alloc(7'd43, 1'b1, 7'd44, 1'b1, 7'd45, 4'd3, 32'hD00B); tick();
    set_alloc(7'd46, 1'b1, 7'd47, 1'b1, 7'd48, 4'd4, 32'hD00C); tick();
    alloc = 1'b0;
    push(7'd43, 7'd44, 7'd45, 4'd3, 32'hD00B);
    push(7'd46, 7'd47, 7'd48, 4'd4, 32'hD00C);
    push(7'd40, 7'd41, 7'd42, 4'd2, 32'hD00A);
    issue_ready = 1'b1;
    tick(); tick();
    chk("a_still_waiting", {31'd0, issue_valid}, 32'd0);
    cdb_valid = 1'b1; cdb_preg = 7'd40;
    tick();
    cdb_valid = 1'b0;
    #1;
    chk("a_offered_prs1", {25'd0, issue_prs1}, 32'd40);
    tick();
    issue_ready = 1'b0;
    #1;
    chk("ooo_empty", {31'd0, issue_valid}, 32'd0);

    // Wakeup of an entry that shifts down in the same edge
    set_alloc(7'd1, 1'b1, 7'd2, 1'b1, 7'd3, 4'd5, 32'hF001); tick();
    set_alloc(7'd50, 1'b0, 7'd51, 1'b1, 7'd52, 4'd6, 32'hF002); tick();
    alloc = 1'b0;
    push(7'd1, 7'd2, 7'd3, 4'd5, 32'hF001);
    push(7'd50, 7'd51, 7'd52, 4'd6, 32'hF002);
    issue_ready = 1'b1; cdb_valid = 1'b1; cdb_preg = 7'd50;
    tick();
    cdb_valid = 1'b0;
    #1;
    chk("shift_wake_payload", issue_payload, 32'hF002);
    tick();
    issue_ready = 1'b0;

    // Same-cycle CDB match on alloc source 2
    cdb_valid = 1'b1; cdb_preg = 7'd9;
    set_alloc(7'd3, 1'b1, 7'd9, 1'b0, 7'd11, 4'd7, 32'hE009);
    tick();
    alloc = 1'b0; cdb_valid = 1'b0;
    #1;
    chk("alloc_cdb_valid", {31'd0, issue_valid}, 32'd1);
    chk("alloc_cdb_prs2", {25'd0, issue_prs2}, 32'd9);
    push(7'd3, 7'd9, 7'd11, 4'd7, 32'hE009);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;

    // Flush with five entries and a concurrent alloc
    for (int i = 0; i < 5; i++) begin
      set_alloc(7'(70 + i), 1'b1, 7'(80 + i), 1'b1, 7'(90 + i), 4'(i), 32'h5000 + 32'(i));
      tick();
    end
    flush = 1'b1;
    set_alloc(7'd12, 1'b1, 7'd13, 1'b1, 7'd14, 4'd9, 32'hEEEE);
    #1;
    chk("flush_cycle_issue_valid", {31'd0, issue_valid}, 32'd0);
    tick();
    flush = 1'b0; alloc = 1'b0;
    #1;
    chk("post_flush_full", {31'd0, full}, 32'd0);
    chk("post_flush_issue_valid", {31'd0, issue_valid}, 32'd0);

    // Reset mid-operation with the FU ready
    set_alloc(7'd15, 1'b1, 7'd16, 1'b1, 7'd17, 4'd1, 32'h7001); tick();
    set_alloc(7'd18, 1'b1, 7'd19, 1'b1, 7'd20, 4'd2, 32'h7002); tick();
    alloc = 1'b0;
    reset = 1'b1; issue_ready = 1'b1;
    #1;
    chk("reset_cycle_issue_valid", {31'd0, issue_valid}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("post_reset_issue_valid", {31'd0, issue_valid}, 32'd0);
    chk("post_reset_full", {31'd0, full}, 32'd0);
    issue_ready = 1'b0;
    tick(); tick();

    chk("scoreboard_leftover", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 Parameters, SHALL exist as listed:
- DEPTH, 8, number of entries (>=2).
- PAYLOAD_W, 32, opaque per-op payload width (opcode/imm/pc).
REQ-002 Ports SHALL be exactly:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- alloc  in  1  allocate one entry this cycle (driven by dispatch).
- alloc_prs1  in  PREG_W  source-1 physical register.
- alloc_rs1_ready  in  1  source-1 value already available.
- alloc_prs2  in  PREG_W  source-2 physical register.
- alloc_rs2_ready  in  1  source-2 value already available.
- alloc_prd  in  PREG_W  destination physical register.
- alloc_rob_tag  in  ROB_W  ROB index of the op.
- alloc_payload  in  PAYLOAD_W  opaque payload.
- full  out  1  no free entry; backpressure to dispatch.
- cdb_valid  in  1  broadcast of a completed result.
- cdb_preg  in  PREG_W  physical register being woken.
- flush  in  1  discard all entries (mispredict recovery).
- issue_valid  out  1  an entry is offered to the FU.
- issue_ready  in  1  FU accepts the offered entry.
- issue_prs1, issue_prs2, issue_prd  out  PREG_W  fields of the offered entry.
- issue_rob_tag  out  ROB_W  ROB tag of the offered entry.
- issue_payload  out  PAYLOAD_W  payload of the offered entry.

Function
REQ-003 Storage SHALL be a collapsing queue: entry 0 is oldest; valid entries always occupy indices 0..count-1.
REQ-004 An entry SHALL hold valid, prs1, rdy1, prs2, rdy2, prd, rob_tag, payload.
REQ-005 full SHALL be a registered flag equal to (count == DEPTH).
REQ-006 alloc with full=0 SHALL write the new entry at index count (after any collapse) at the next edge. alloc with full=1 SHALL be ignored.
REQ-007 An entry SHALL be ready when valid && rdy1 && rdy2. issue_valid SHALL be combinational: high when any entry is ready.
REQ-008 The issue_* fields SHALL come from the lowest-index (oldest) ready entry.
REQ-009 An issue handshake (issue_valid && issue_ready) SHALL remove the offered entry at the edge. Entries above it shift down one index. count decrements.
REQ-010 A cdb_valid edge SHALL set rdy1 (or rdy2) in every valid entry whose prs1 (or prs2) equals cdb_preg. Wakeup has no same-cycle bypass: the woken entry first becomes issuable the following cycle.
REQ-011 If cdb_valid matches an alloc_prs* in the same cycle, the allocated entry SHALL store that operand as ready.
REQ-012 Alloc-to-issue minimum latency SHALL be 1 cycle: with both operands ready, alloc at edge N gives issue_valid in cycle N+1.
REQ-013 Simultaneous issue and alloc in one cycle SHALL do both: the collapse applies first, the new entry lands at index count-1, and count is unchanged.
REQ-014 Wakeup SHALL also apply to entries shifting during the same edge.
REQ-015 flush SHALL clear all valid bits and count at the next edge. Alloc and issue in a flush cycle are dropped, and issue_valid SHALL be 0 while flush=1.
REQ-016 count SHALL be $clog2(DEPTH+1) bits and never exceed DEPTH or underflow.

Reset
REQ-017 reset SHALL clear all valid bits and count on the next edge; full=0 and issue_valid=0 thereafter.
REQ-018 reset SHALL take priority over flush, alloc, issue and wakeup in the same cycle.
REQ-019 Reset mid-operation SHALL discard all entries, with no issue in the reset cycle.

Structure
REQ-020 Shared package SHALL hold:
- PREG_W=7 and ROB_W=4.
- fu_type_t enum: FU_ALU=2'b00, FU_BRANCH=2'b01, FU_LSU=2'b10.
- rs_entry_t struct.
REQ-021 One instance per FU class SHALL be used. Dispatch's alu/branch/lsu_rs_alloc drives alloc, and full feeds back to dispatch.
REQ-022 Sub-module rs_select SHALL implement the lowest-index ready priority picker, outputting a one-hot grant and a valid flag.

Verification
REQ-023 Reset, then alloc 8 ops with rdy1=rdy2=1 and issue_ready=0 -> full=1 after the 8th edge; a 9th alloc is ignored and count stays 8.
REQ-024 Alloc prs1=5 (rdy1=0), rdy2=1 -> issue_valid=0; then cdb_valid with cdb_preg=5 -> issue_valid=1 exactly one cycle later, with issue_prs1=5.
REQ-025 Entries A (not ready), B (ready), C (ready) with issue_ready=1 -> B issues, then C; A stays at index 0 and issues after its wakeup.
REQ-026 Full queue, issue_ready=1, alloc=1 in the same cycle -> one issue and one alloc, count stays 8, and the new entry is last in order.
REQ-027 Alloc with alloc_prs2=9, rdy2=0, while cdb_preg=9 and cdb_valid=1 in the same cycle -> entry issuable the next cycle.
REQ-028 Five valid entries, then flush=1 with alloc=1 -> next cycle count=0, full=0, issue_valid=0, and the alloc is dropped.
